nch_frame_mixer: RTL and testbench

NCH_FRAME_MIXER -- requirements
Module: nch_frame_mixer

---
 rtl/nch_frame_mixer.sv | 173 +++++++++++++++++
 tb/tb_nch_frame_mixer.sv | 522 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nch_frame_mixer.sv
// nch_frame_mixer: merges framed word streams from NUM_CH first-word-fall-through FIFOs onto one
// valid/ready output. A grant is issued round-robin and kept for a whole frame, so frames are
// never interleaved. Malformed frames are repaired on the fly:
//   - a first word without a header ID gets ERR_HEADER_ID in its MSBs (HDR_ERR_CNT++)
//   - a frame reaching MAX_FRAME_LEN words without a footer gets ERR_FOOTER_ID in the LSBs of its
//     last word (FTR_ERR_CNT++)
//   - a header appearing mid-frame closes the frame with an injected {0, ERR_FOOTER_ID} word
//     (FTR_ERR_CNT++). The header itself stays in the FIFO and opens the channel's next frame.
//
// Ports:
//   CLK, RESET        clock and asynchronous active-high reset
//   CH_DIN            per-channel FIFO head words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   CH_READ_REQUEST   per-channel FIFO non-empty flags
//   CH_RE             per-channel pop strobes (one-hot or zero)
//   iREADY            downstream accepts DOUT
//   DOUT/oVALID/oLAST output word, valid flag and frame footer flag
//   CUR_CH            granted channel (last granted channel while idle)
//   HDR_ERR_CNT       saturating count of repaired headers
//   FTR_ERR_CNT       saturating count of forced or injected footers
module nch_frame_mixer #(
  parameter int                     DATA_WIDTH    = 64,
  parameter int                     NUM_CH        = 4,
  parameter int                     ID_WIDTH      = 16,
  parameter logic [ID_WIDTH-1:0]    HEADER_ID     = 16'hAAAA,
  parameter logic [ID_WIDTH-1:0]    FOOTER_ID     = 16'h5555,
  parameter logic [ID_WIDTH-1:0]    ERR_HEADER_ID = 16'hAAEE,
  parameter logic [ID_WIDTH-1:0]    ERR_FOOTER_ID = 16'h55EE,
  parameter int                     MAX_FRAME_LEN = 256
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NUM_CH*DATA_WIDTH-1:0] CH_DIN,
  input  logic [NUM_CH-1:0]            CH_READ_REQUEST,
  output logic [NUM_CH-1:0]            CH_RE,
  input  logic                         iREADY,
  output logic [DATA_WIDTH-1:0]        DOUT,
  output logic                         oVALID,
  output logic                         oLAST,
  output logic [$clog2(NUM_CH)-1:0]    CUR_CH,
  output logic [15:0]                  HDR_ERR_CNT,
  output logic [15:0]                  FTR_ERR_CNT
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(MAX_FRAME_LEN + 1);
  // word_cnt value while the final permitted word of a frame is being consumed
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StStream, StInject} state_e;

  state_e                state;
  logic [CH_W-1:0]       grant;
  logic [CH_W-1:0]       last_grant;
  logic [CH_W-1:0]       rr_pick;
  logic [CH_W-1:0]       rr_idx;
  logic [CNT_W-1:0]      word_cnt;

  logic [DATA_WIDTH-1:0] din_g;
  logic [DATA_WIDTH-1:0] word_out;
  logic [ID_WIDTH-1:0]   din_msb;
  logic [ID_WIDTH-1:0]   din_lsb;
  logic                  can_load;
  logic                  is_hdr;
  logic                  is_ftr;
  logic                  mid_hdr;
  logic                  pop;
  logic                  hdr_bad;
  logic                  ftr_hit;
  logic                  len_hit;
  logic                  frame_end;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Round-robin: scan downwards so the requester closest after last_grant is written last.
  always_comb begin
    rr_pick = last_grant;
    rr_idx  = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      rr_idx = CH_W'((int'(last_grant) + i) % NUM_CH);
      if (CH_READ_REQUEST[rr_idx]) rr_pick = rr_idx;
    end
  end

  assign din_g    = CH_DIN[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign din_msb  = din_g[DATA_WIDTH-1 -: ID_WIDTH];
  assign din_lsb  = din_g[ID_WIDTH-1:0];
  assign is_hdr   = (din_msb == HEADER_ID) || (din_msb == ERR_HEADER_ID);
  assign is_ftr   = (din_lsb == FOOTER_ID) || (din_lsb == ERR_FOOTER_ID);
  assign can_load = !oVALID || iREADY;
  assign mid_hdr  = (word_cnt != '0) && is_hdr;

  assign pop = (state == StStream) && CH_READ_REQUEST[grant] && can_load && !mid_hdr;

  // Footer detection is suppressed on the first word so a header is never taken as a footer.
  assign hdr_bad   = (word_cnt == '0) && !is_hdr;
  assign ftr_hit   = (word_cnt != '0) && is_ftr;
  assign len_hit   = !ftr_hit && (word_cnt == LAST_CNT);
  assign frame_end = ftr_hit || len_hit;

  always_comb begin
    word_out = din_g;
    if (hdr_bad) word_out[DATA_WIDTH-1 -: ID_WIDTH] = ERR_HEADER_ID;
    if (len_hit) word_out[ID_WIDTH-1:0] = ERR_FOOTER_ID;
  end

  always_comb begin
    CH_RE = '0;
    if (pop) CH_RE[grant] = 1'b1;
  end

  assign CUR_CH = (state == StIdle) ? last_grant : grant;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= StIdle;
      grant       <= '0;
      last_grant  <= CH_W'(NUM_CH - 1);
      word_cnt    <= '0;
      DOUT        <= {(DATA_WIDTH/4){4'hE}};
      oVALID      <= 1'b0;
      oLAST       <= 1'b0;
      HDR_ERR_CNT <= '0;
      FTR_ERR_CNT <= '0;
    end else begin
      // Output drains when accepted; a load below overrides this.
      if (iREADY) begin
        oVALID <= 1'b0;
        oLAST  <= 1'b0;
      end
      unique case (state)
        StIdle: begin
          if (|CH_READ_REQUEST) begin
            grant <= rr_pick;
            state <= StStream;
          end
        end
        StStream: begin
          if (pop) begin
            DOUT   <= word_out;
            oVALID <= 1'b1;
            oLAST  <= frame_end;
            if (hdr_bad) HDR_ERR_CNT <= sat_inc(HDR_ERR_CNT);
            if (len_hit) FTR_ERR_CNT <= sat_inc(FTR_ERR_CNT);
            if (frame_end) begin
              word_cnt   <= '0;
              last_grant <= grant;
              state      <= StIdle;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end else if (CH_READ_REQUEST[grant] && mid_hdr) begin
            state <= StInject;
          end
        end
        StInject: begin
          if (can_load) begin
            DOUT        <= {{(DATA_WIDTH-ID_WIDTH){1'b0}}, ERR_FOOTER_ID};
            oVALID      <= 1'b1;
            oLAST       <= 1'b1;
            FTR_ERR_CNT <= sat_inc(FTR_ERR_CNT);
            word_cnt    <= '0;
            last_grant  <= grant;
            state       <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nch_frame_mixer.sv
// Bench for nch_frame_mixer. Channel FIFOs are arrays in the bench; expected output is derived by
// parsing each channel's word stream into repaired frames and merging them round-robin.
module tb_nch_frame_mixer;

  localparam int DW     = 64;
  localparam int NCH    = 4;
  localparam int IDW    = 16;
  localparam int MAXLEN = 8;
  localparam int DEPTH  = 1024;
  localparam int EDEPTH = 256;
  localparam logic [15:0] HDR  = 16'hAAAA;
  localparam logic [15:0] FTR  = 16'h5555;
  localparam logic [15:0] EHDR = 16'hAAEE;
  localparam logic [15:0] EFTR = 16'h55EE;
  localparam logic [DW-1:0] RST_DOUT = 64'hEEEE_EEEE_EEEE_EEEE;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH*DW-1:0] ch_din;
  logic [NCH-1:0]  ch_req;
  logic [NCH-1:0]  ch_re;
  logic            iready;
  logic [DW-1:0]   dout;
  logic            ovalid;
  logic            olast;
  logic [1:0]      cur_ch;
  logic [15:0]     hdr_cnt;
  logic [15:0]     ftr_cnt;

  nch_frame_mixer #(
    .DATA_WIDTH   (DW),
    .NUM_CH       (NCH),
    .ID_WIDTH     (IDW),
    .MAX_FRAME_LEN(MAXLEN)
  ) dut (
    .CLK            (clk),
    .RESET          (rst),
    .CH_DIN         (ch_din),
    .CH_READ_REQUEST(ch_req),
    .CH_RE          (ch_re),
    .iREADY         (iready),
    .DOUT           (dout),
    .oVALID         (ovalid),
    .oLAST          (olast),
    .CUR_CH         (cur_ch),
    .HDR_ERR_CNT    (hdr_cnt),
    .FTR_ERR_CNT    (ftr_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] in_mem [NCH][DEPTH];
  int            in_rd [NCH];
  int            in_wr [NCH];
  logic [DW:0]   ch_exp [NCH][EDEPTH];
  int            ce_rd [NCH];
  int            ce_wr [NCH];
  logic [DW:0]   exp_seq [$];
  int            exp_last;
  int            exp_hdr;
  int            exp_ftr;
  int            cyc;
  int            acc_cyc [$];
  logic          acc_last [$];
  logic [DW-1:0] acc_data [$];
  int            vectors;
  int            miscompares;

  function automatic logic is_hdr_id(input logic [15:0] v);
    return (v == HDR) || (v == EHDR);
  endfunction

  function automatic logic is_ftr_id(input logic [15:0] v);
    return (v == FTR) || (v == EFTR);
  endfunction

  // Payload word that can never look like a header (MSB clear) or a footer (LSBs < 0x4000).
  function automatic logic [DW-1:0] data_word();
    return {1'b0, 15'($urandom), $urandom, 2'b00, 14'($urandom)};
  endfunction

  function automatic logic all_consumed();
    for (int c = 0; c < NCH; c++) if (in_rd[c] != in_wr[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load(input int ch, input logic [DW-1:0] w);
    in_mem[ch][in_wr[ch]] = w;
    in_wr[ch]++;
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < NCH; c++) begin
      ch_req[c] = (in_rd[c] < in_wr[c]);
      ch_din[c*DW +: DW] = ch_req[c] ? in_mem[c][in_rd[c]] : '0;
    end
  endtask

  task automatic clear_log();
    acc_cyc.delete();
    acc_last.delete();
    acc_data.delete();
  endtask

  // Split every channel's pending words into repaired frames, then merge them round-robin.
  task automatic build_expected();
    int pick;
    for (int ch = 0; ch < NCH; ch++) begin
      int cnt;
      cnt = 0;
      ce_rd[ch] = 0;
      ce_wr[ch] = 0;
      for (int k = in_rd[ch]; k < in_wr[ch]; k++) begin
        logic [DW-1:0] w;
        w = in_mem[ch][k];
        if (cnt > 0 && is_hdr_id(w[DW-1 -: IDW])) begin
          ch_exp[ch][ce_wr[ch]] = {1'b1, {(DW-IDW){1'b0}}, EFTR};
          ce_wr[ch]++;
          exp_ftr++;
          cnt = 0;
        end
        if (cnt == 0 && !is_hdr_id(w[DW-1 -: IDW])) begin
          w[DW-1 -: IDW] = EHDR;
          exp_hdr++;
        end
        cnt++;
        if (cnt > 1 && is_ftr_id(w[IDW-1:0])) begin
          ch_exp[ch][ce_wr[ch]] = {1'b1, w};
          cnt = 0;
        end else if (cnt == MAXLEN) begin
          w[IDW-1:0] = EFTR;
          ch_exp[ch][ce_wr[ch]] = {1'b1, w};
          exp_ftr++;
          cnt = 0;
        end else begin
          ch_exp[ch][ce_wr[ch]] = {1'b0, w};
        end
        ce_wr[ch]++;
      end
    end
    while (1) begin
      pick = -1;
      for (int i = 1; i <= NCH; i++) begin
        int c;
        c = (exp_last + i) % NCH;
        if (pick < 0 && ce_rd[c] < ce_wr[c]) pick = c;
      end
      if (pick < 0) break;
      while (1) begin
        logic [DW:0] e;
        e = ch_exp[pick][ce_rd[pick]];
        ce_rd[pick]++;
        exp_seq.push_back(e);
        if (e[DW]) break;
      end
      exp_last = pick;
    end
  endtask

  // One clock: set iREADY, sample before the edge, then pop FIFOs and score any accepted word.
  task automatic tick(input logic rdy);
    logic [NCH-1:0] re;
    logic           v;
    logic           l;
    logic           r;
    logic [DW-1:0]  d;
    @(negedge clk);
    iready = rdy;
    #1;
    re = ch_re;
    v  = ovalid;
    l  = olast;
    r  = iready;
    d  = dout;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) if (re[c]) in_rd[c]++;
    drive_inputs();
    if (v && r) begin
      acc_cyc.push_back(cyc);
      acc_last.push_back(l);
      acc_data.push_back(d);
      vectors++;
      if (exp_seq.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_extra: got last=%0b data=%h, required no word", l, d);
      end else begin
        logic [DW:0] e;
        e = exp_seq.pop_front();
        if ({l, d} !== e) begin
          miscompares++;
          $display("FAIL scoreboard: got last=%0b data=%h, required last=%0b data=%h",
                   l, d, e[DW], e[DW-1:0]);
        end
      end
    end
  endtask

  task automatic drain(input int budget, input bit rnd);
    int n;
    n = 0;
    while (!(exp_seq.size() == 0 && all_consumed() && !ovalid) && n < budget) begin
      tick(rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      n++;
    end
    vectors++;
    if (!(exp_seq.size() == 0 && all_consumed() && !ovalid)) begin
      miscompares++;
      $display("FAIL drain: got %0d words still expected after %0d cycles, required 0",
               exp_seq.size(), n);
    end
  endtask

  task automatic check_counters(input string tag);
    vectors++;
    if (hdr_cnt !== 16'(exp_hdr)) begin
      miscompares++;
      $display("FAIL %s hdr_err_cnt: got %0d, required %0d", tag, hdr_cnt, exp_hdr);
    end
    vectors++;
    if (ftr_cnt !== 16'(exp_ftr)) begin
      miscompares++;
      $display("FAIL %s ftr_err_cnt: got %0d, required %0d", tag, ftr_cnt, exp_ftr);
    end
  endtask

  task automatic reset_model();
    for (int c = 0; c < NCH; c++) in_rd[c] = in_wr[c];
    exp_seq.delete();
    exp_last = NCH - 1;
    exp_hdr  = 0;
    exp_ftr  = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (dout !== RST_DOUT) begin
      miscompares++;
      $display("FAIL %s dout: got %h, required %h", tag, dout, RST_DOUT);
    end
    vectors++;
    if (ovalid !== 1'b0 || olast !== 1'b0) begin
      miscompares++;
      $display("FAIL %s valid_last: got %0b%0b, required 00", tag, ovalid, olast);
    end
    vectors++;
    if (ch_re !== '0) begin
      miscompares++;
      $display("FAIL %s ch_re: got %b, required 0", tag, ch_re);
    end
    vectors++;
    if (cur_ch !== 2'(NCH - 1)) begin
      miscompares++;
      $display("FAIL %s cur_ch: got %0d, required %0d", tag, cur_ch, NCH - 1);
    end
    vectors++;
    if (hdr_cnt !== 16'd0 || ftr_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL %s counters: got %0d/%0d, required 0/0", tag, hdr_cnt, ftr_cnt);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    iready = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      in_rd[c] = 0;
      in_wr[c] = 0;
    end
    reset_model();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Ch0 and ch2 each hold a 4-word frame; ch0's header LSBs equal the footer ID.
  task automatic test_two_channels();
    clear_log();
    load(0, {HDR, 32'h0, FTR});
    load(0, data_word());
    load(0, data_word());
    load(0, {16'h0100, 32'h3333_3333, FTR});
    load(2, {HDR, 32'h2, 16'h0002});
    load(2, data_word());
    load(2, data_word());
    load(2, {16'h0200, 32'h4444_4444, EFTR});
    build_expected();
    drive_inputs();
    drain(100, 1'b0);
    vectors++;
    if (acc_cyc.size() !== 8) begin
      miscompares++;
      $display("FAIL two_ch_count: got %0d words, required 8", acc_cyc.size());
    end else begin
      vectors++;
      if (acc_cyc[3] - acc_cyc[0] !== 3 || acc_last[3] !== 1'b1) begin
        miscompares++;
        $display("FAIL two_ch_frame0: got span %0d last %0b, required span 3 last 1",
                 acc_cyc[3] - acc_cyc[0], acc_last[3]);
      end
      vectors++;
      if (acc_cyc[4] - acc_cyc[3] !== 2) begin
        miscompares++;
        $display("FAIL two_ch_gap: got %0d cycles, required 2", acc_cyc[4] - acc_cyc[3]);
      end
    end
    check_counters("two_ch");
  endtask

  task automatic test_bad_header();
    logic [DW-1:0] first;
    clear_log();
    load(1, {16'h1234, 32'h0, 16'h0000});
    load(1, data_word());
    load(1, {16'h0300, 32'h5, FTR});
    build_expected();
    drive_inputs();
    drain(100, 1'b0);
    first = (acc_data.size() > 0) ? acc_data[0] : '0;
    vectors++;
    if (first[DW-1 -: IDW] !== EHDR) begin
      miscompares++;
      $display("FAIL bad_hdr_msb: got %h, required %h", first[DW-1 -: IDW], EHDR);
    end
    vectors++;
    if (hdr_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL bad_hdr_cnt: got %0d, required 1", hdr_cnt);
    end
    check_counters("bad_hdr");
  endtask

  task automatic test_mid_header();
    logic [DW-1:0] hdr2;
    logic [DW-1:0] w;
    clear_log();
    hdr2 = {HDR, 32'h2, 16'h0202};
    load(3, {HDR, 32'h1, 16'h0101});
    load(3, data_word());
    load(3, hdr2);
    load(3, data_word());
    load(3, {16'h0400, 32'h6, FTR});
    build_expected();
    drive_inputs();
    drain(100, 1'b0);
    vectors++;
    if (acc_data.size() !== 6) begin
      miscompares++;
      $display("FAIL mid_hdr_count: got %0d words, required 6", acc_data.size());
    end else begin
      w = acc_data[2];
      vectors++;
      if (w !== {{(DW-IDW){1'b0}}, EFTR} || acc_last[2] !== 1'b1) begin
        miscompares++;
        $display("FAIL mid_hdr_inject: got %h last %0b, required %h last 1",
                 w, acc_last[2], {{(DW-IDW){1'b0}}, EFTR});
      end
      w = acc_data[3];
      vectors++;
      if (w !== hdr2) begin
        miscompares++;
        $display("FAIL mid_hdr_next: got %h, required %h", w, hdr2);
      end
    end
    vectors++;
    if (ftr_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL mid_hdr_ftr_cnt: got %0d, required 1", ftr_cnt);
    end
    check_counters("mid_hdr");
  endtask

  // Ten words with no footer; a trailing footer closes the leftover words.
  task automatic test_overlong();
    logic [DW-1:0] w;
    clear_log();
    load(0, {HDR, 32'h8, 16'h0808});
    for (int i = 0; i < 9; i++) load(0, data_word());
    load(0, {16'h0500, 32'h9, FTR});
    build_expected();
    drive_inputs();
    drain(100, 1'b0);
    vectors++;
    if (acc_data.size() < 8) begin
      miscompares++;
      $display("FAIL overlong_count: got %0d words, required 11", acc_data.size());
    end else begin
      w = acc_data[7];
      vectors++;
      if (w[IDW-1:0] !== EFTR || acc_last[7] !== 1'b1) begin
        miscompares++;
        $display("FAIL overlong_word8: got lsb %h last %0b, required %h last 1",
                 w[IDW-1:0], acc_last[7], EFTR);
      end
    end
    check_counters("overlong");
  endtask

  task automatic test_backpressure();
    logic [DW:0] e;
    clear_log();
    load(2, {HDR, 32'hB, 16'h0B0B});
    for (int i = 0; i < 5; i++) load(2, data_word());
    load(2, {16'h0600, 32'hC, FTR});
    build_expected();
    drive_inputs();
    repeat (3) tick(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      e = exp_seq[0];
      vectors++;
      if (ovalid !== 1'b1 || dout !== e[DW-1:0]) begin
        miscompares++;
        $display("FAIL stall_hold: got valid %0b data %h, required valid 1 data %h",
                 ovalid, dout, e[DW-1:0]);
      end
      vectors++;
      if (ch_re !== '0) begin
        miscompares++;
        $display("FAIL stall_re: got %b, required 0", ch_re);
      end
    end
    drain(100, 1'b0);
    vectors++;
    if (acc_data.size() !== 7) begin
      miscompares++;
      $display("FAIL stall_count: got %0d words, required 7", acc_data.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    clear_log();
    load(1, {HDR, 32'hD, 16'h0D0D});
    for (int i = 0; i < 4; i++) load(1, data_word());
    load(1, {16'h0700, 32'hE, FTR});
    build_expected();
    drive_inputs();
    n = 0;
    while (in_rd[1] < 3 && n < 20) begin
      tick(1'b1);
      n++;
    end
    vectors++;
    if (in_rd[1] < 3) begin
      miscompares++;
      $display("FAIL rst_mid_progress: got %0d words consumed, required 3", in_rd[1]);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    @(negedge clk);
    reset_model();
    load(1, {HDR, 32'hF, 16'h0F0F});
    load(1, {16'h0800, 32'h10, FTR});
    load(0, {HDR, 32'h11, 16'h1111});
    load(0, {16'h0900, 32'h12, FTR});
    build_expected();
    drive_inputs();
    rst = 1'b0;
    tick(1'b1);
    vectors++;
    if (cur_ch !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_mid_first_grant: got %0d, required 0", cur_ch);
    end
    drain(100, 1'b0);
    check_counters("rst_mid");
  endtask

  task automatic gen_channel(input int ch, input int nframes);
    for (int f = 0; f < nframes; f++) begin
      int kind;
      int nd;
      kind = (f == nframes - 1) ? 0 : int'($urandom_range(0, 3));
      nd   = int'($urandom_range(0, 4));
      if (kind == 1) load(ch, data_word());
      else load(ch, {($urandom_range(0, 1) != 0) ? HDR : EHDR, $urandom,
                     ($urandom_range(0, 3) == 0) ? FTR : 16'(14'($urandom))});
      if (kind == 3) nd = 9;
      for (int i = 0; i < nd; i++) load(ch, data_word());
      if (kind < 2) load(ch, {1'b0, 15'($urandom), $urandom,
                              ($urandom_range(0, 1) != 0) ? FTR : EFTR});
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      clear_log();
      for (int c = 0; c < NCH; c++)
        if (c == r % NCH || $urandom_range(0, 1) != 0) gen_channel(c, int'($urandom_range(1, 4)));
      build_expected();
      drive_inputs();
      drain(3000, 1'b1);
      check_counters("random");
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    ch_din      = '0;
    ch_req      = '0;
    test_reset();
    test_two_channels();
    test_bad_header();
    test_mid_header();
    test_overlong();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
